// File: rtl/gpu_pkg.sv
// rtl/gpu_pkg.sv - shared gpu types, limits and helpers
// Purpose: arbiter FSM state enum, maximum channel count, one-hot decode.
// Ports: none (package).
package gpu_pkg;

    localparam int GPU_MAX_CH  = 8;
    localparam int GPU_MAX_IDW = 3;

    typedef enum logic {
        ARB = 1'b0,
        OWN = 1'b1
    } arb_state_e;

    // Index of the set bit in a one-hot vector; zero for an all-zero vector.
    function automatic logic [GPU_MAX_IDW-1:0] onehot_to_idx(input logic [GPU_MAX_CH-1:0] oh);
        logic [GPU_MAX_IDW-1:0] idx;
        idx = '0;
        for (int i = 0; i < GPU_MAX_CH; i++) begin
            if (oh[i]) begin
                idx = GPU_MAX_IDW'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/gpu_definitions.vh
// rtl/gpu_definitions.vh - screen coordinate widths shared by the gpu blocks
`ifndef GPU_DEFINITIONS_VH
`define GPU_DEFINITIONS_VH

`define WIDTH_BITS  10
`define HEIGHT_BITS 9

`endif

// File: rtl/gpu_rr_arbiter.sv
// rtl/gpu_rr_arbiter.sv - combinational round-robin / fixed-priority grant
// Purpose: picks one requester and returns a one-hot grant.
// Ports:
//   req_i        - request vector, one bit per channel
//   last_owner_i - channel granted most recently (round-robin pointer)
//   grant_o      - one-hot grant, all zero when nothing requests
module gpu_rr_arbiter
    import gpu_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int RR_EN  = 1,
    parameter int IDW    = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req_i,
    input  logic [IDW-1:0]    last_owner_i,
    output logic [NUM_CH-1:0] grant_o
);

    logic           found;
    logic [IDW-1:0] idx;

    always_comb begin
        grant_o = '0;
        found   = 1'b0;
        idx     = '0;
        if (RR_EN != 0) begin
            // Scan starts one past the last owner and wraps, so the last owner
            // is considered only after every other channel.
            for (int i = 1; i <= NUM_CH; i++) begin
                idx = IDW'((int'(last_owner_i) + i) % NUM_CH);
                if (!found && req_i[idx]) begin
                    grant_o[idx] = 1'b1;
                    found        = 1'b1;
                end
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (!found && req_i[i]) begin
                    grant_o[i] = 1'b1;
                    found      = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/gpu_output_arbiter.sv
// rtl/gpu_output_arbiter.sv - merges rasteriser pixel streams into one output
// Purpose: grants one channel at a time, keeps a primitive's pixels together,
//          and registers the winning pixel for the downstream consumer.
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   ch_valid_i/last_i   - per-channel pixel valid / last pixel of primitive
//   ch_x_i, ch_y_i      - packed per-channel coordinates (channel k at k*W)
//   ch_ready_o          - per-channel accept, at most one bit set
//   x_o, y_o, ch_id_o   - registered output pixel and its source channel
//   data_ready_o        - output pixel valid
//   out_ready_i         - downstream accept
//   pixel_count_o       - pixels delivered downstream since reset
`include "gpu_definitions.vh"

module gpu_output_arbiter
    import gpu_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int XW     = `WIDTH_BITS,
    parameter int YW     = `HEIGHT_BITS,
    parameter int RR_EN  = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_CH-1:0]          ch_valid_i,
    input  logic [NUM_CH-1:0]          ch_last_i,
    input  logic [NUM_CH*XW-1:0]       ch_x_i,
    input  logic [NUM_CH*YW-1:0]       ch_y_i,
    output logic [NUM_CH-1:0]          ch_ready_o,
    output logic [XW-1:0]              x_o,
    output logic [YW-1:0]              y_o,
    output logic [$clog2(NUM_CH)-1:0]  ch_id_o,
    output logic                       data_ready_o,
    input  logic                       out_ready_i,
    output logic [31:0]                pixel_count_o
);

    localparam int IDW = $clog2(NUM_CH);

    arb_state_e        state_q;
    logic [IDW-1:0]    owner_q;
    logic [IDW-1:0]    last_owner_q;
    logic [XW-1:0]     x_q;
    logic [YW-1:0]     y_q;
    logic [IDW-1:0]    id_q;
    logic              dv_q;
    logic [31:0]       cnt_q;
    logic [31:0]       cnt_d;

    logic [NUM_CH-1:0] arb_grant;
    logic [NUM_CH-1:0] grant;
    logic [IDW-1:0]    gidx;
    logic              can_load;
    logic              xfer;

    gpu_rr_arbiter #(
        .NUM_CH (NUM_CH),
        .RR_EN  (RR_EN),
        .IDW    (IDW)
    ) u_arb (
        .req_i        (ch_valid_i),
        .last_owner_i (last_owner_q),
        .grant_o      (arb_grant)
    );

    always_comb begin
        // Output register can take a pixel when empty or draining this cycle.
        can_load = !dv_q || out_ready_i;
        grant    = '0;
        gidx     = '0;
        if (state_q == OWN) begin
            // The owner keeps the grant even with valid low: no interleaving.
            grant[owner_q] = 1'b1;
            gidx           = owner_q;
        end else begin
            grant = arb_grant;
            gidx  = IDW'(onehot_to_idx(GPU_MAX_CH'(arb_grant)));
        end
        ch_ready_o = (can_load && !rst) ? grant : '0;
        xfer       = |(ch_valid_i & ch_ready_o);
        cnt_d      = (dv_q && out_ready_i) ? cnt_q + 32'd1 : cnt_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ARB;
            owner_q      <= '0;
            last_owner_q <= IDW'(NUM_CH - 1);
            x_q          <= '0;
            y_q          <= '0;
            id_q         <= '0;
            dv_q         <= 1'b0;
            cnt_q        <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (xfer) begin
                x_q          <= ch_x_i[gidx*XW +: XW];
                y_q          <= ch_y_i[gidx*YW +: YW];
                id_q         <= gidx;
                dv_q         <= 1'b1;
                last_owner_q <= gidx;
            end else if (out_ready_i) begin
                dv_q <= 1'b0;
            end
            case (state_q)
                ARB: begin
                    if (xfer && !ch_last_i[gidx]) begin
                        state_q <= OWN;
                        owner_q <= gidx;
                    end
                end
                OWN: begin
                    if (xfer && ch_last_i[gidx]) begin
                        state_q <= ARB;
                    end
                end
                default: state_q <= ARB;
            endcase
        end
    end

    assign x_o           = x_q;
    assign y_o           = y_q;
    assign ch_id_o       = id_q;
    assign data_ready_o  = dv_q;
    assign pixel_count_o = cnt_q;

endmodule

// File: tb/tb_gpu_output_arbiter.sv
// tb/tb_gpu_output_arbiter.sv - self-checking bench for gpu_output_arbiter
module tb_gpu_output_arbiter;

    localparam int NCH = 4;
    localparam int XW  = 10;
    localparam int YW  = 9;
    localparam int IW  = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [NCH-1:0]    ch_valid_i;
    logic [NCH-1:0]    ch_last_i;
    logic [NCH*XW-1:0] ch_x_i;
    logic [NCH*YW-1:0] ch_y_i;
    logic              out_ready_i = 1'b1;

    logic [NCH-1:0] rr_ready, fp_ready;
    logic [XW-1:0]  rr_x, fp_x;
    logic [YW-1:0]  rr_y, fp_y;
    logic [IW-1:0]  rr_id, fp_id;
    logic           rr_dr, fp_dr;
    logic [31:0]    rr_cnt, fp_cnt;

    gpu_output_arbiter #(.NUM_CH(NCH), .XW(XW), .YW(YW), .RR_EN(1)) u_rr (
        .clk(clk), .rst(rst), .ch_valid_i(ch_valid_i), .ch_last_i(ch_last_i),
        .ch_x_i(ch_x_i), .ch_y_i(ch_y_i), .ch_ready_o(rr_ready), .x_o(rr_x), .y_o(rr_y),
        .ch_id_o(rr_id), .data_ready_o(rr_dr), .out_ready_i(out_ready_i), .pixel_count_o(rr_cnt));

    gpu_output_arbiter #(.NUM_CH(NCH), .XW(XW), .YW(YW), .RR_EN(0)) u_fp (
        .clk(clk), .rst(rst), .ch_valid_i(ch_valid_i), .ch_last_i(ch_last_i),
        .ch_x_i(ch_x_i), .ch_y_i(ch_y_i), .ch_ready_o(fp_ready), .x_o(fp_x), .y_o(fp_y),
        .ch_id_o(fp_id), .data_ready_o(fp_dr), .out_ready_i(out_ready_i), .pixel_count_o(fp_cnt));

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [XW-1:0] x;
        logic [YW-1:0] y;
        logic [IW-1:0] id;
    } exp_t;
    exp_t sb[$];
    int   exp_cnt = 0;

    // Per-channel pixel sources
    logic [XW-1:0] mx[NCH][256];
    logic [YW-1:0] my[NCH][256];
    logic          ml[NCH][256];
    int            head[NCH] = '{0, 0, 0, 0};
    int            tail[NCH] = '{0, 0, 0, 0};
    logic [NCH-1:0] gap = '0;
    bit            use_fp = 1'b0;
    logic [NCH-1:0] rdy_sel;

    assign rdy_sel = use_fp ? fp_ready : rr_ready;

    always_comb begin
        ch_valid_i = '0;
        ch_last_i  = '0;
        ch_x_i     = '0;
        ch_y_i     = '0;
        for (int k = 0; k < NCH; k++) begin
            ch_x_i[k*XW +: XW] = mx[k][head[k] % 256];
            ch_y_i[k*YW +: YW] = my[k][head[k] % 256];
            if (head[k] < tail[k] && !gap[k]) begin
                ch_valid_i[k] = 1'b1;
                ch_last_i[k]  = ml[k][head[k] % 256];
            end
        end
    end

    always @(posedge clk) begin
        for (int k = 0; k < NCH; k++) begin
            if (rst) head[k] <= tail[k];
            else if (ch_valid_i[k] && rdy_sel[k]) head[k] <= head[k] + 1;
        end
    end

    // Scoreboard monitor: a downstream transfer happens at the next rising edge
    always @(negedge clk) begin
        exp_t got;
        exp_t e;
        if (!rst && (use_fp ? fp_dr : rr_dr) && out_ready_i) begin
            got.x  = use_fp ? fp_x : rr_x;
            got.y  = use_fp ? fp_y : rr_y;
            got.id = use_fp ? fp_id : rr_id;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: got x=%0d y=%0d id=%0d, required no output", got.x, got.y, got.id);
            end else begin
                e = sb.pop_front();
                if (got !== e) begin
                    errors++;
                    $display("FAIL sb_pixel: got x=%0d y=%0d id=%0d, required x=%0d y=%0d id=%0d",
                             got.x, got.y, got.id, e.x, e.y, e.id);
                end
            end
            exp_cnt++;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int ch, input int x, input int y, input bit last);
        mx[ch][tail[ch] % 256] = XW'(x);
        my[ch][tail[ch] % 256] = YW'(y);
        ml[ch][tail[ch] % 256] = last;
        tail[ch]++;
    endtask

    task automatic expect_pix(input int x, input int y, input int id);
        exp_t e;
        e.x  = XW'(x);
        e.y  = YW'(y);
        e.id = IW'(id);
        sb.push_back(e);
    endtask

    task automatic do_reset;
        rst = 1'b1;
        gap = '0;
        sb.delete();
        exp_cnt = 0;
        tick;
        tick;
        rst = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (sb.size() != 0 && n < 60) begin
            tick;
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s_timeout: %0d pixels outstanding, required 0", name, sb.size());
        end
        checks++;
        if ((use_fp ? fp_cnt : rr_cnt) !== 32'(exp_cnt)) begin
            errors++;
            $display("FAIL %s_count: got %0d, required %0d", name, (use_fp ? fp_cnt : rr_cnt), exp_cnt);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick;
        push(0, 5, 5, 1'b1);
        #1;
        checks++; if (rr_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready: got %b, required 0000", rr_ready); end
        checks++; if (fp_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready_fp: got %b, required 0000", fp_ready); end
        checks++; if (rr_dr !== 1'b0) begin errors++; $display("FAIL reset_dr: got %b, required 0", rr_dr); end
        checks++; if (rr_x !== '0 || rr_y !== '0) begin errors++; $display("FAIL reset_xy: got %0d,%0d, required 0,0", rr_x, rr_y); end
        checks++; if (rr_id !== '0) begin errors++; $display("FAIL reset_id: got %0d, required 0", rr_id); end
        checks++; if (rr_cnt !== 32'd0) begin errors++; $display("FAIL reset_count: got %0d, required 0", rr_cnt); end
        do_reset;
    endtask

    task automatic test_round_robin;
        int n = 0;
        do_reset;
        use_fp = 1'b0;
        out_ready_i = 1'b1;
        push(0, 10, 1, 1'b1); push(0, 11, 1, 1'b1);
        push(2, 30, 3, 1'b1); push(2, 31, 3, 1'b1);
        expect_pix(10, 1, 0); expect_pix(30, 3, 2);
        expect_pix(11, 1, 0); expect_pix(31, 3, 2);
        while (sb.size() != 0 && n < 40) begin
            tick;
            n++;
        end
        checks++;
        if (n != 5) begin errors++; $display("FAIL rr_throughput: got %0d cycles, required 5", n); end
        checks++;
        if (rr_cnt !== 32'(exp_cnt)) begin errors++; $display("FAIL rr_count: got %0d, required %0d", rr_cnt, exp_cnt); end
    endtask

    task automatic test_fixed_priority;
        do_reset;
        use_fp = 1'b1;
        out_ready_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            push(1, 100 + i, 20, 1'b1);
            expect_pix(100 + i, 20, 1);
        end
        for (int i = 0; i < 2; i++) begin
            push(3, 200 + i, 30, 1'b1);
            expect_pix(200 + i, 30, 3);
        end
        #1;
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (fp_ready !== 4'b0010) begin errors++; $display("FAIL fp_grant: cycle %0d got %b, required 0010", i, fp_ready); end
            tick;
        end
        drain("fp");
        use_fp = 1'b0;
    endtask

    task automatic test_own;
        do_reset;
        out_ready_i = 1'b1;
        push(1, 10, 5, 1'b0); push(1, 11, 5, 1'b0); push(1, 12, 5, 1'b1);
        expect_pix(10, 5, 1); expect_pix(11, 5, 1); expect_pix(12, 5, 1);
        tick;
        push(0, 50, 7, 1'b1);
        expect_pix(50, 7, 0);
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if (rr_ready !== 4'b0010) begin errors++; $display("FAIL own_grant: cycle %0d got %b, required 0010", i, rr_ready); end
            tick;
        end
        drain("own");
    endtask

    task automatic test_stall;
        do_reset;
        out_ready_i = 1'b0;
        push(0, 20, 2, 1'b1); push(2, 40, 4, 1'b1);
        expect_pix(20, 2, 0); expect_pix(40, 4, 2);
        tick;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (rr_dr !== 1'b1 || rr_x !== 10'd20 || rr_y !== 9'd2 || rr_id !== 2'd0) begin
                errors++;
                $display("FAIL stall_hold: cycle %0d got dr=%b x=%0d y=%0d id=%0d, required dr=1 x=20 y=2 id=0",
                         i, rr_dr, rr_x, rr_y, rr_id);
            end
            checks++;
            if (rr_ready !== 4'b0000) begin errors++; $display("FAIL stall_ready: cycle %0d got %b, required 0000", i, rr_ready); end
            checks++;
            if (rr_cnt !== 32'd0) begin errors++; $display("FAIL stall_count: cycle %0d got %0d, required 0", i, rr_cnt); end
            tick;
        end
        out_ready_i = 1'b1;
        drain("stall");
    endtask

    task automatic test_reset_mid;
        do_reset;
        out_ready_i = 1'b1;
        push(3, 90, 9, 1'b1);
        expect_pix(90, 9, 3);
        drain("pre_rst");
        out_ready_i = 1'b0;
        push(2, 60, 6, 1'b0); push(2, 61, 6, 1'b0); push(2, 62, 6, 1'b1);
        tick;
        checks++;
        if (rr_dr !== 1'b1) begin errors++; $display("FAIL mid_loaded: got dr=%b, required 1", rr_dr); end
        rst = 1'b1;
        sb.delete();
        exp_cnt = 0;
        tick;
        checks++;
        if (rr_dr !== 1'b0 || rr_cnt !== 32'd0) begin
            errors++;
            $display("FAIL mid_reset: got dr=%b count=%0d, required dr=0 count=0", rr_dr, rr_cnt);
        end
        rst = 1'b0;
        out_ready_i = 1'b1;
        push(1, 70, 1, 1'b1); push(2, 80, 2, 1'b1);
        expect_pix(70, 1, 1); expect_pix(80, 2, 2);
        #1;
        checks++;
        if (rr_ready !== 4'b0010) begin errors++; $display("FAIL mid_first_grant: got %b, required 0010", rr_ready); end
        drain("mid");
    endtask

    task automatic test_owner_gap;
        do_reset;
        out_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            push(0, 1 + i, 8, (i == 3));
            expect_pix(1 + i, 8, 0);
        end
        tick;
        push(1, 99, 9, 1'b1);
        expect_pix(99, 9, 1);
        tick;
        gap[0] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (rr_ready !== 4'b0001) begin errors++; $display("FAIL gap_grant: cycle %0d got %b, required 0001", i, rr_ready); end
            tick;
        end
        gap[0] = 1'b0;
        drain("gap");
    endtask

    initial begin
        test_reset;
        test_round_robin;
        test_fixed_priority;
        test_own;
        test_stall;
        test_reset_mid;
        test_owner_gap;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gpu_output_arbiter.md
GPU_OUTPUT_ARBITER -- requirements
Module: gpu_output_arbiter

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of rasteriser channels (2..8).
REQ-002 SHALL have parameter XW, default `WIDTH_BITS: x coordinate width.
REQ-003 SHALL have parameter YW, default `HEIGHT_BITS: y coordinate width.
REQ-004 SHALL have parameter RR_EN, default 1: 1 = round-robin arbitration, 0 = fixed priority with channel 0 highest.
REQ-005 SHALL have port clk, input, 1: the single clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-007 SHALL have port ch_valid_i, input, NUM_CH: per-channel pixel valid.
REQ-008 SHALL have port ch_last_i, input, NUM_CH: per-channel last pixel of the current primitive.
REQ-009 SHALL have port ch_x_i, input, NUM_CH*XW: packed x; channel k at bits [k*XW +: XW].
REQ-010 SHALL have port ch_y_i, input, NUM_CH*YW: packed y, same packing as ch_x_i.
REQ-011 SHALL have port ch_ready_o, output, NUM_CH: per-channel accept; at most one bit set.
REQ-012 SHALL have port x_o, output, XW: registered pixel x.
REQ-013 SHALL have port y_o, output, YW: registered pixel y.
REQ-014 SHALL have port ch_id_o, output, $clog2(NUM_CH): source channel of the pixel on x_o/y_o.
REQ-015 SHALL have port data_ready_o, output, 1: output pixel valid.
REQ-016 SHALL have port out_ready_i, input, 1: downstream accept.
REQ-017 SHALL have port pixel_count_o, output, 32: pixels delivered downstream since reset.

Function
REQ-018 SHALL transfer on a channel when ch_valid_i[k] and ch_ready_o[k] are both high at a clock edge; downstream transfer when data_ready_o and out_ready_i are both high.
REQ-019 SHALL drive ch_ready_o[g] high only for the granted channel g, and only when the output register is empty or being emptied in the same cycle (out_ready_i high), giving one pixel per cycle throughput.
REQ-020 SHALL make ch_ready_o combinational from the state, ch_valid_i and out_ready_i, with no path from ch_x_i or ch_y_i.
REQ-021 SHALL load x_o, y_o and ch_id_o on every channel transfer, giving 1-cycle latency from transfer to data_ready_o.
REQ-022 SHALL hold x_o, y_o, ch_id_o and data_ready_o stable while data_ready_o is high and out_ready_i is low.
REQ-023 SHALL implement an FSM with states ARB and OWN.
REQ-024 In ARB, SHALL pick grant g among the valid channels: lowest index when RR_EN=0; first valid index after last_owner, with wrap-around, when RR_EN=1.
REQ-025 SHALL go from ARB to OWN on a channel transfer with ch_last_i[g] low, latching g as owner; a transfer with ch_last_i high stays in ARB.
REQ-026 In OWN, SHALL grant only the owner, even when the owner's valid is low, so primitives are never interleaved.
REQ-027 SHALL go from OWN to ARB on the cycle after a transfer with ch_last_i[owner] high.
REQ-028 SHALL update last_owner on every channel transfer.
REQ-029 SHALL drive no ch_ready_o bit when no channel is valid in ARB.
REQ-030 SHALL increment pixel_count_o by 1 on each downstream transfer, wrapping modulo 2^32.
REQ-031 SHALL ignore ch_last_i when ch_valid_i is low.

Reset
REQ-032 While rst is high, SHALL hold state=ARB, last_owner=NUM_CH-1, data_ready_o=0, x_o=0, y_o=0, ch_id_o=0, pixel_count_o=0 and ch_ready_o=0.
REQ-033 SHALL discard any in-flight primitive and any pixel in the output register when rst asserts mid-operation; the first grant after release goes to the lowest valid channel.

Structure
REQ-034 SHALL place the ARB/OWN state enum and the NUM_CH maximum constant in the shared gpu package; XW and YW defaults SHALL come from gpu_definitions.vh.
REQ-035 SHALL implement the arbiter as one sub-module, gpu_rr_arbiter (request vector, last_owner, RR_EN -> one-hot grant); register and FSM logic stay in the top.

Verification
REQ-036 V1: RR_EN=1, channels 0 and 2 valid, each sending single-pixel primitives (last=1), out_ready_i=1 -> ch_id_o sequence 0,2,0,2 and one pixel per cycle.
REQ-037 V2: RR_EN=0, channels 1 and 3 valid continuously -> every grant goes to channel 1; channel 3 starves.
REQ-038 V3: channel 1 sends 3 pixels (last on the third) at (10,5),(11,5),(12,5), channel 0 valid throughout -> outputs in order (10,5),(11,5),(12,5) with ch_id_o=1, then channel 0.
REQ-039 V4: out_ready_i low for 5 cycles with data_ready_o high -> x_o, y_o and ch_id_o unchanged, all ch_ready_o low, pixel_count_o unchanged.
REQ-040 V5: rst pulsed while in OWN for channel 2 with data_ready_o high -> next cycle data_ready_o=0 and pixel_count_o=0; after release, valid channels 1 and 2 -> grant to channel 1.
REQ-041 V6: owner channel 0 drops valid for 3 cycles mid-primitive while channel 1 is valid -> no ch_ready_o[1] during the gap; channel 0 resumes and finishes first.
